// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher feeding the IFU instruction fifo.
//   Issues in-order AR reads at fetch_pc, pushes {err, pc, inst} for each R beat,
//   and limits outstanding reads so the fifo can always absorb every response.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   redirect_valid_i/   flush fifo and restart fetch at redirect_pc_i (low 2 bits ignored)
//   redirect_pc_i
//   ar_valid_o/ar_ready_i/ar_addr_o     read request channel
//   r_valid_i/r_ready_o/r_data_i/r_resp_i  read response channel
//   fifo_wr_en_o/fifo_data_o            push {err, pc, inst} into the fifo
//   fifo_clr_o                          synchronous clear of the fifo
//   fifo_rd_en_i                        consumer pop, tracks fifo occupancy
module ifu_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]            redirect_pc_i,
    output logic                             ar_valid_o,
    input  logic                             ar_ready_i,
    output logic [ADDR_WIDTH-1:0]            ar_addr_o,
    input  logic                             r_valid_i,
    output logic                             r_ready_o,
    input  logic [DATA_WIDTH-1:0]            r_data_i,
    input  logic [1:0]                       r_resp_i,
    output logic                             fifo_wr_en_o,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   fifo_data_o,
    output logic                             fifo_clr_o,
    input  logic                             fifo_rd_en_i
);
    localparam int CW = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, ar_addr_q, ar_addr_d;
    logic [CW-1:0]           inflight_q, inflight_d, occ_q, occ_d;
    logic                    ar_valid_q, ar_valid_d, r_ready_q;
    logic                    redir, ar_hs, r_hs, ar_pend, push, pop, issue;
    logic [ADDR_WIDTH-1:0]   redir_pc, pc_src;

    // r_ready_q doubles as the "out of reset" flag, so nothing reacts while in reset.
    always_comb begin
        redir      = redirect_valid_i & r_ready_q;
        redir_pc   = redirect_pc_i & MASK;
        ar_hs      = ar_valid_q & ar_ready_i;
        ar_pend    = ar_valid_q & ~ar_ready_i;
        r_hs       = r_valid_i & r_ready_q;
        push       = (state_q == RUN) & r_hs & ~redir;
        pop        = fifo_rd_en_i & (occ_q != '0);
        inflight_d = inflight_q + CW'(ar_hs) - CW'(r_hs);
        occ_d      = redir ? '0 : occ_q + CW'(push) - CW'(pop);
        state_d    = redir ? ((state_q == DRAIN || inflight_d != '0 || ar_pend) ? DRAIN : RUN) :
                     (push && r_resp_i != 2'b00) ? HALT :
                     (state_q == DRAIN && inflight_d == '0 && !ar_pend) ? RUN : state_q;
        // Credits are judged on next-cycle counts so an accepted AR is never double counted.
        issue      = ~ar_pend & (state_d == RUN) & (inflight_d < MAX_C) & ((inflight_d + occ_d) < DEPTH_C);
        ar_valid_d = ar_pend | issue;
        // fetch_pc is the next address to request; it advances when a request is raised,
        // while ar_addr_q holds a pending request stable across redirects.
        pc_src     = redir ? redir_pc : fetch_pc_q;
        fetch_pc_d = issue ? pc_src + STEP : pc_src;
        ar_addr_d  = issue ? pc_src : ar_addr_q;
        resp_pc_d  = redir ? redir_pc : push ? resp_pc_q + STEP : resp_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            ar_addr_q  <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            ar_addr_q  <= ar_addr_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= 1'b1;
        end
    end

    assign ar_valid_o   = ar_valid_q;
    assign ar_addr_o    = ar_addr_q;
    assign r_ready_o    = r_ready_q;
    assign fifo_wr_en_o = push;
    assign fifo_data_o  = {r_resp_i != 2'b00, resp_pc_q, r_data_i};
    assign fifo_clr_o   = redir;
endmodule
